// File: rtl/hash_avalon_pkg.sv
// Shared definitions for the hash Avalon-MM slave: register map, STATUS/CTRL
// bit positions, FSM state encoding and a byte-lane merge helper.
package hash_avalon_pkg;

    localparam int unsigned REG_LEN    = 0;
    localparam int unsigned REG_DATA   = 1;
    localparam int unsigned REG_STATUS = 2;
    localparam int unsigned REG_CTRL   = 3;
    localparam int unsigned REG_CLEAR  = 4;
    localparam int unsigned REG_DIGEST = 16;

    localparam int ST_BUSY      = 0;
    localparam int ST_READY     = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_EMPTY     = 3;
    localparam int ST_OVF       = 4;
    localparam int ST_ERR       = 5;
    localparam int ST_IRQ_EN    = 6;
    localparam int ST_LEVEL_LSB = 8;

    localparam int CTRL_START  = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2
    } state_e;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hash_msg_fifo.sv
// Synchronous 32-bit message FIFO with flush; a push while full is accepted
// when a pop happens in the same cycle.
module hash_msg_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [31:0]                wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [31:0]                rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
            if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/hash_avalon_slave.sv
// Avalon-MM front end feeding a hash core from a message FIFO and capturing
// its digest. Optional `HASH_IRQ_EN adds a registered irq output.
module hash_avalon_slave #(
    parameter int FIFO_DEPTH   = 16,
    parameter int DIGEST_WORDS = 8,
    parameter int LEN_W        = 16,
    parameter int ADDR_W       = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          address,
    input  logic [31:0]                writedata,
    input  logic [3:0]                 byteenable,
    input  logic                       write,
    input  logic                       read,
    input  logic                       chipselect,
    output logic [31:0]                readdata,
    output logic                       core_start,
    output logic [LEN_W-1:0]           core_len_bits,
    output logic [31:0]                core_msg_data,
    output logic                       core_msg_valid,
    output logic                       core_msg_last,
    input  logic                       core_msg_ready,
    input  logic [32*DIGEST_WORDS-1:0] core_digest,
    input  logic                       core_digest_valid
`ifdef HASH_IRQ_EN
    ,
    output logic                       irq
`endif
);
    import hash_avalon_pkg::*;

    localparam int WL_W   = LEN_W - 4;
    localparam int DW_IDX = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [WL_W-1:0]   words_left_q, words_left_d;
    logic              core_start_q, core_start_d;
    logic [LEN_W-1:0]  core_len_q, core_len_d;
    logic              hash_ready_q, hash_ready_d;
    logic              overflow_q, overflow_d;
    logic              error_q, error_d;
    logic              irq_en_q, irq_en_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [31:0]       dig_q [DIGEST_WORDS];
    logic [31:0]       dig_d [DIGEST_WORDS];

    logic              wr, rd, wr_len, wr_data, wr_ctrl, wr_clear;
    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [31:0]       fifo_rdata;
    logic [LVL_W-1:0]  fifo_level;
    logic [LEN_W:0]    len_round;
    logic              dig_hit;
    logic [31:0]       status, rdata_mux;

    assign wr       = chipselect && write;
    assign rd       = chipselect && read;
    assign wr_len   = wr && (address == ADDR_W'(REG_LEN));
    assign wr_data  = wr && (address == ADDR_W'(REG_DATA));
    assign wr_ctrl  = wr && (address == ADDR_W'(REG_CTRL));
    assign wr_clear = wr && (address == ADDR_W'(REG_CLEAR));

    assign core_msg_valid = (state_q == FEED) && !fifo_empty;
    assign core_msg_data  = core_msg_valid ? fifo_rdata : '0;
    assign core_msg_last  = (state_q == FEED) && (words_left_q == WL_W'(1));
    assign core_start     = core_start_q;
    assign core_len_bits  = core_len_q;
    assign readdata       = readdata_q;
    assign fifo_pop       = core_msg_valid && core_msg_ready;
    assign fifo_push      = wr_data;

    // Word count of the message, rounded up to whole 32-bit words.
    assign len_round = {1'b0, len_q} + (LEN_W+1)'(31);

    hash_msg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (fifo_push),
        .wdata_i (lane_merge('0, writedata, byteenable)),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        words_left_d = words_left_q;
        core_start_d = 1'b0;
        core_len_d   = core_len_q;
        hash_ready_d = hash_ready_q;
        overflow_d   = overflow_q;
        error_d      = error_q;
        irq_en_d     = irq_en_q;
        dig_d        = dig_q;
        fifo_flush   = 1'b0;

        if (wr_len) len_d = LEN_W'(lane_merge(32'(len_q), writedata, byteenable));
        if (wr_data && fifo_full && !fifo_pop) overflow_d = 1'b1;

        if (wr_ctrl) begin
`ifdef HASH_IRQ_EN
            irq_en_d = writedata[CTRL_IRQ_EN];
`endif
            if (writedata[CTRL_FLUSH]) begin
                if (state_q == IDLE) fifo_flush = 1'b1;
                else                 error_d    = 1'b1;
            end
            if (writedata[CTRL_START]) begin
                if (state_q == IDLE && len_q != '0) begin
                    state_d      = FEED;
                    core_start_d = 1'b1;
                    core_len_d   = len_q;
                    words_left_d = len_round[LEN_W:5];
                end else begin
                    error_d = 1'b1;
                end
            end
        end

        // CLEAR is applied before the digest capture so a coincident capture wins.
        if (wr_clear) begin
            hash_ready_d = 1'b0;
            overflow_d   = 1'b0;
            error_d      = 1'b0;
        end

        case (state_q)
            FEED: begin
                if (fifo_pop) begin
                    words_left_d = words_left_q - WL_W'(1);
                    if (words_left_q == WL_W'(1)) state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_digest_valid) begin
                    for (int i = 0; i < DIGEST_WORDS; i++) dig_d[i] = core_digest[32*i +: 32];
                    hash_ready_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        status                          = '0;
        status[ST_BUSY]                 = (state_q != IDLE);
        status[ST_READY]                = hash_ready_q;
        status[ST_FULL]                 = fifo_full;
        status[ST_EMPTY]                = fifo_empty;
        status[ST_OVF]                  = overflow_q;
        status[ST_ERR]                  = error_q;
        status[ST_IRQ_EN]               = irq_en_q;
        status[ST_LEVEL_LSB +: 8]       = 8'(fifo_level);

        dig_hit   = ((address >> 4) == ADDR_W'(1)) && ({1'b0, address[3:0]} < 5'(DIGEST_WORDS));
        rdata_mux = '0;
        if (address == ADDR_W'(REG_LEN))         rdata_mux = 32'(len_q);
        else if (address == ADDR_W'(REG_STATUS)) rdata_mux = status;
        else if (dig_hit)                        rdata_mux = dig_q[address[DW_IDX-1:0]];

        readdata_d = rd ? rdata_mux : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            words_left_q <= '0;
            core_start_q <= 1'b0;
            core_len_q   <= '0;
            hash_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b0;
            irq_en_q     <= 1'b0;
            readdata_q   <= '0;
            for (int i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            words_left_q <= words_left_d;
            core_start_q <= core_start_d;
            core_len_q   <= core_len_d;
            hash_ready_q <= hash_ready_d;
            overflow_q   <= overflow_d;
            error_q      <= error_d;
            irq_en_q     <= irq_en_d;
            readdata_q   <= readdata_d;
            dig_q        <= dig_d;
        end
    end

`ifdef HASH_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= hash_ready_q && irq_en_q && !wr_clear;
    end
    assign irq = irq_q;
`endif

endmodule
